// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and address-width helper for regfile_mp
package regfile_pkg;

    typedef enum logic {IDLE, CLEAR} state_t;

    function automatic int addr_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sweeps a zero through every entry after reset or a clear request
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int COUNT = 32,
    parameter int ADDRW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    output logic             busy,
    output logic             clr_we,
    output logic [ADDRW-1:0] clr_addr
);

    localparam logic [ADDRW-1:0] LAST = ADDRW'(COUNT - 1);

    state_t           state;
    logic [ADDRW-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= '0;
        end else if (state == CLEAR) begin
            state <= (ptr == LAST) ? IDLE : CLEAR;
            ptr   <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end else if (clear) begin
            state <= CLEAR;
            ptr   <= '0;
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with bypass, zero register and clear sweep
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  DATAWIDTH = 32,
    parameter int  COUNT     = 32,
    parameter int  NREAD     = 2,
    parameter bit  BYPASS    = 1'b1,
    parameter bit  ZERO_REG  = 1'b1,
    localparam int ADDRW     = addr_width(COUNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREAD*ADDRW-1:0]     readReg,
    output logic [NREAD*DATAWIDTH-1:0] readData,
    input  logic [ADDRW-1:0]           writeReg,
    input  logic [DATAWIDTH-1:0]       writeData,
    input  logic                       write,
    input  logic                       clear,
    output logic                       busy
);

    localparam logic [ADDRW:0] CNT = (ADDRW + 1)'(COUNT);

    logic [DATAWIDTH-1:0] mem [COUNT];
    logic                 clr_we;
    logic [ADDRW-1:0]     clr_addr;
    logic                 we;
    logic [ADDRW-1:0]     wa;
    logic [DATAWIDTH-1:0] wd;

    regfile_clear_fsm #(.COUNT(COUNT), .ADDRW(ADDRW)) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // The sweep owns the single array write port while busy.
    assign we = clr_we || (write && ({1'b0, writeReg} < CNT) && !(ZERO_REG && writeReg == '0));
    assign wa = clr_we ? clr_addr : writeReg;
    assign wd = clr_we ? '0 : writeData;

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDRW-1:0] ra;
        assign ra = readReg[k*ADDRW +: ADDRW];
        assign readData[k*DATAWIDTH +: DATAWIDTH] =
            (busy || ({1'b0, ra} >= CNT) || (ZERO_REG && ra == '0)) ? '0 :
            (BYPASS && write && writeReg == ra)                     ? writeData :
                                                                      mem[ra];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table and sequence checks of regfile_mp in three configurations, scoreboard-compared
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // u0: defaults (32x32, 2 ports, bypass, zero reg)
    logic [9:0]  rr0;
    logic [63:0] rd0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we0, cl0, b0;
    // u1: no bypass, no zero reg
    logic [9:0]  rr1;
    logic [63:0] rd1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        we1, cl1, b1;
    // u2: COUNT=20, NREAD=4, DATAWIDTH=16
    logic [19:0] rr2;
    logic [63:0] rd2;
    logic [4:0]  wa2;
    logic [15:0] wd2;
    logic        we2, cl2, b2;

    regfile_mp u0 (
        .clk(clk), .rst_n(rst_n), .readReg(rr0), .readData(rd0), .writeReg(wa0),
        .writeData(wd0), .write(we0), .clear(cl0), .busy(b0)
    );
    regfile_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .readReg(rr1), .readData(rd1), .writeReg(wa1),
        .writeData(wd1), .write(we1), .clear(cl1), .busy(b1)
    );
    regfile_mp #(.COUNT(20), .NREAD(4), .DATAWIDTH(16)) u2 (
        .clk(clk), .rst_n(rst_n), .readReg(rr2), .readData(rd2), .writeReg(wa2),
        .writeData(wd2), .write(we2), .clear(cl2), .busy(b2)
    );

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    exp_t q[$];
    vec_t tbl[8];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push(input string nm, input logic [31:0] v);
        q.push_back('{nm, v});
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        exp_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got %h with no expected value", act);
        end else begin
            e = q.pop_front();
            if (act !== e.v) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.nm, act, e.v);
            end
        end
    endtask

    task automatic count_fall(output int n0, output int n1, output int n2);
        n0 = -1; n1 = -1; n2 = -1;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk); #1;
            if (!b0 && n0 < 0) n0 = i;
            if (!b1 && n1 < 0) n1 = i;
            if (!b2 && n2 < 0) n2 = i;
        end
    endtask

    task automatic sweep_checks(input string tag);
        int n0, n1, n2;
        count_fall(n0, n1, n2);
        push({tag, "_u0_edges"}, 32); pop_cmp(n0);
        push({tag, "_u1_edges"}, 32); pop_cmp(n1);
        push({tag, "_u2_edges"}, 20); pop_cmp(n2);
    endtask

    task automatic read_all_zero_u0(input string tag);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rr0 = {5'(31 - a), 5'(a)};
            #1;
            push({tag, "_p0"}, 0); pop_cmp(rd0[31:0]);
            push({tag, "_p1"}, 0); pop_cmp(rd0[63:32]);
        end
    endtask

    initial begin
        int n;
        rr0 = '0; wa0 = '0; wd0 = '0; we0 = 0; cl0 = 0;
        rr1 = '0; wa1 = '0; wd1 = '0; we1 = 0; cl1 = 0;
        rr2 = '0; wa2 = '0; wd2 = '0; we2 = 0; cl2 = 0;

        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h0};
        tbl[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, 32'hA5A5A5A5, 32'h0};
        tbl[5] = '{1'b1, 5'd30, 32'h0F0F0F0F, 5'd31, 5'd30, 32'hA5A5A5A5, 32'h0F0F0F0F};
        tbl[6] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd30, 32'h11111111, 32'h0F0F0F0F};
        tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'h11111111, 32'h11111111};

        // reset sweep
        repeat (3) @(negedge clk);
        #1;
        push("reset_busy", 1);      pop_cmp(b0);
        push("reset_readdata", 0);  pop_cmp(rd0[31:0]);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_checks("reset");
        read_all_zero_u0("post_reset");

        // write/read, bypass and zero register on u0
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we0 = tbl[i].wr; wa0 = tbl[i].wa; wd0 = tbl[i].wd;
            rr0 = {tbl[i].ra1, tbl[i].ra0};
            push($sformatf("tbl%0d_p0", i), tbl[i].e0);
            push($sformatf("tbl%0d_p1", i), tbl[i].e1);
            #1;
            pop_cmp(rd0[31:0]);
            pop_cmp(rd0[63:32]);
        end
        @(negedge clk);
        we0 = 0;

        // no bypass, no zero register on u1
        we1 = 1; wa1 = 5; wd1 = 32'hDEADBEEF; rr1 = {5'd0, 5'd5};
        push("nobyp_old", 0); #1; pop_cmp(rd1[31:0]);
        @(negedge clk);
        wa1 = 0; wd1 = 32'h1234;
        push("nobyp_next", 32'hDEADBEEF); push("nozero_old", 0);
        #1; pop_cmp(rd1[31:0]); pop_cmp(rd1[63:32]);
        @(negedge clk);
        we1 = 0;
        push("nozero_r0", 32'h1234); #1; pop_cmp(rd1[63:32]);

        // clear with concurrent write on u0
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we0 = 1; wa0 = 5'(i); wd0 = i;
        end
        @(negedge clk);
        we0 = 0; rr0 = {5'd31, 5'd7};
        push("fill_r7", 7); push("fill_r31", 31);
        #1; pop_cmp(rd0[31:0]); pop_cmp(rd0[63:32]);
        @(negedge clk);
        cl0 = 1; we0 = 1; wa0 = 7; wd0 = 32'hFF; rr0 = {5'd7, 5'd7};
        push("clr_edge_bypass", 32'hFF);
        #1; pop_cmp(rd0[31:0]);
        @(posedge clk); #1;
        cl0 = 0; we0 = 1; wa0 = 3; wd0 = 32'h33; rr0 = {5'd3, 5'd31};
        #1;
        push("clr_busy", 1);       pop_cmp(b0);
        push("clr_read_r31", 0);   pop_cmp(rd0[31:0]);
        push("clr_read_byp_r3", 0); pop_cmp(rd0[63:32]);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk); #1;
            if (!b0) begin
                n = i;
                break;
            end
        end
        we0 = 0;
        push("clr_busy_cycles", 32); pop_cmp(n);
        read_all_zero_u0("post_clear");

        // reset mid-sweep; u1 is idle so its busy must rise without a clock edge
        @(negedge clk);
        cl0 = 1;
        @(posedge clk); #1;
        cl0 = 0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        push("async_rst_u1_busy", 1); pop_cmp(b1);
        push("async_rst_u0_busy", 1); pop_cmp(b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sweep_checks("midsweep");

        // generalisation on u2
        @(negedge clk);
        we2 = 1; wa2 = 3; wd2 = 16'hAAAA;
        @(negedge clk);
        wa2 = 19; wd2 = 16'h1919;
        @(negedge clk);
        wa2 = 0; wd2 = 16'h7777;
        @(negedge clk);
        wa2 = 25; wd2 = 16'h2525; rr2 = {5'd25, 5'd25, 5'd25, 5'd25};
        push("u2_oob_bypass", 0); #1; pop_cmp(rd2[15:0]);
        @(negedge clk);
        we2 = 0; rr2 = {5'd0, 5'd19, 5'd3, 5'd3};
        push("u2_p0_r3", 16'hAAAA); push("u2_p1_r3", 16'hAAAA);
        push("u2_p2_r19", 16'h1919); push("u2_p3_r0", 0);
        #1;
        pop_cmp(rd2[15:0]); pop_cmp(rd2[31:16]); pop_cmp(rd2[47:32]); pop_cmp(rd2[63:48]);
        @(negedge clk);
        rr2 = {5'd19, 5'd25, 5'd5, 5'd25};
        push("u2_read_oob", 0); push("u2_r5_alias", 0); push("u2_read_oob2", 0);
        push("u2_r19_again", 16'h1919);
        #1;
        pop_cmp(rd2[15:0]); pop_cmp(rd2[31:16]); pop_cmp(rd2[47:32]); pop_cmp(rd2[63:48]);
        @(negedge clk);
        we2 = 1; wa2 = 3; wd2 = 16'hBBBB; rr2 = {5'd0, 5'd0, 5'd0, 5'd3};
        push("u2_bypass_r3", 16'hBBBB); #1; pop_cmp(rd2[15:0]);
        @(negedge clk);
        we2 = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
